// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// The result is computed when the operation starts and committed after a fixed busy window.
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        state_q, state_d;
    logic [3:0]  counter_q, counter_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        commit_q, commit_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pending_hi_q, pending_hi_d;
    logic [31:0] pending_lo_q, pending_lo_d;

    // op[0] clear selects the signed flavour for both multiply and divide.
    logic        is_signed;
    logic [63:0] mul_a, mul_b, product;
    assign is_signed = ~op[0];
    assign mul_a     = {(is_signed ? {32{A[31]}} : 32'h0), A};
    assign mul_b     = {(is_signed ? {32{B[31]}} : 32'h0), B};
    assign product   = mul_a * mul_b;

    // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
    logic        a_neg, b_neg;
    logic [31:0] dividend, divisor_mag, divisor, quo_mag, rem_mag, quotient, remainder;
    assign a_neg       = is_signed & A[31];
    assign b_neg       = is_signed & B[31];
    assign dividend    = a_neg ? (32'h0 - A) : A;
    assign divisor_mag = b_neg ? (32'h0 - B) : B;
    assign divisor     = (B == 32'h0) ? 32'h1 : divisor_mag;
    assign quo_mag     = dividend / divisor;
    assign rem_mag     = dividend % divisor;
    assign quotient    = (a_neg ^ b_neg) ? (32'h0 - quo_mag) : quo_mag;
    assign remainder   = a_neg ? (32'h0 - rem_mag) : rem_mag;

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        commit_d     = commit_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pending_hi_d = pending_hi_q;
        pending_lo_d = pending_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            pending_hi_d = product[63:32];
                            pending_lo_d = product[31:0];
                            commit_d     = 1'b1;
                            counter_d    = MULT_CYCLES[3:0];
                            busy_d       = 1'b1;
                            state_d      = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pending_hi_d = remainder;
                            pending_lo_d = quotient;
                            commit_d     = (B != 32'h0);
                            counter_d    = DIV_CYCLES[3:0];
                            busy_d       = 1'b1;
                            state_d      = S_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            default: begin
                // Any start seen here is dropped; the window always runs to completion.
                counter_d = counter_q - 4'd1;
                if (counter_q == 4'd1) begin
                    if (commit_q) begin
                        hi_d = pending_hi_q;
                        lo_d = pending_lo_q;
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            counter_q    <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            commit_q     <= 1'b0;
            hi_q         <= 32'h0;
            lo_q         <= 32'h0;
            pending_hi_q <= 32'h0;
            pending_lo_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            commit_q     <= commit_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pending_hi_q <= pending_hi_d;
            pending_lo_q <= pending_lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer with hand-computed HI/LO results.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int total;
    int bad;

    muldiv_sequencer #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Presents one start pulse at a falling edge; returns at the next falling edge (cycle 1).
    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        A     = 32'h0;
        B     = 32'h0;
    endtask

    // Walks an n-cycle busy window and checks the committed HI/LO and the done pulse.
    task automatic run_window(input string tag, input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                              input logic [31:0] old_hi, input logic [31:0] old_lo);
        for (int i = 1; i <= n; i++) begin
            check_output({tag, " busy"}, {31'h0, busy}, 32'h1);
            check_output({tag, " done_low"}, {31'h0, done}, 32'h0);
            check_output({tag, " hi_stale"}, HI, old_hi);
            check_output({tag, " lo_stale"}, LO, old_lo);
            @(negedge clk);
        end
        check_output({tag, " busy_end"}, {31'h0, busy}, 32'h0);
        check_output({tag, " done"}, {31'h0, done}, 32'h1);
        check_output({tag, " hi"}, HI, exp_hi);
        check_output({tag, " lo"}, LO, exp_lo);
        @(negedge clk);
        check_output({tag, " done_clear"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        A     = 32'h0;
        B     = 32'h0;
        #12;
        check_output("reset busy", {31'h0, busy}, 32'h0);
        check_output("reset done", {31'h0, done}, 32'h0);
        check_output("reset hi", HI, 32'h0);
        check_output("reset lo", LO, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        apply_stimulus(3'b000, 32'hFFFF_FFFE, 32'h3);
        run_window("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0, 32'h0);

        apply_stimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_window("multu", 5, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        apply_stimulus(3'b010, 32'hFFFF_FFF9, 32'h2);
        run_window("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0001);

        apply_stimulus(3'b011, 32'h7, 32'h2);
        run_window("divu", 10, 32'h1, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        apply_stimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        run_window("div_ovf", 10, 32'h0, 32'h8000_0000, 32'h1, 32'h3);

        apply_stimulus(3'b100, 32'h11, 32'h0);
        check_output("mthi busy", {31'h0, busy}, 32'h0);
        check_output("mthi hi", HI, 32'h11);
        apply_stimulus(3'b101, 32'h22, 32'h0);
        check_output("mtlo done", {31'h0, done}, 32'h0);
        check_output("mtlo lo", LO, 32'h22);

        apply_stimulus(3'b110, 32'h55, 32'h66);
        check_output("rsvd busy", {31'h0, busy}, 32'h0);
        check_output("rsvd hi", HI, 32'h11);
        check_output("rsvd lo", LO, 32'h22);

        apply_stimulus(3'b010, 32'h5, 32'h0);
        run_window("div0", 10, 32'h11, 32'h22, 32'h11, 32'h22);

        // MULT in flight, MTLO attempted in cycle 3, then an asynchronous reset.
        apply_stimulus(3'b000, 32'h4, 32'h5);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 3'b101;
        A     = 32'hDEAD;
        @(posedge clk);
        #1;
        check_output("busy_mtlo lo", LO, 32'h22);
        check_output("busy_mtlo busy", {31'h0, busy}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_output("midreset busy", {31'h0, busy}, 32'h0);
        check_output("midreset hi", HI, 32'h0);
        check_output("midreset lo", LO, 32'h0);
        start = 1'b0;
        A     = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("postreset done", {31'h0, done}, 32'h0);
            check_output("postreset busy", {31'h0, busy}, 32'h0);
        end

        apply_stimulus(3'b000, 32'h2, 32'h3);
        run_window("mult_after", 5, 32'h0, 32'h6, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
